// File: rtl/pixel_stream_packer_pkg.sv
// rtl/pixel_stream_packer_pkg.sv - shared video types and depth shading helper
// Purpose: RGB888 pixel type, AXIS pixel payload struct, fixed-point fraction
// width and the depth-to-grey shading function used by the packer.
package pixel_stream_packer_pkg;

   // Fractional bits of the vec3 fixed-point components (Q15.16).
   localparam int FRAC_BITS = 16;

   typedef logic [23:0] rgb888_t;

   // Payload carried through the output FIFO, MSB first: {tlast, tuser, rgb}.
   typedef struct packed {
      logic    tlast;
      logic    tuser;
      rgb888_t rgb;
   } axis_pix_t;

   // Grey level falls off linearly with depth in 1/16 units. Anything behind
   // the camera (z < 0) is treated as fully lit; far points clamp to black.
   function automatic rgb888_t shade_depth(input logic signed [31:0] z,
                                           input logic              hit,
                                           input rgb888_t           bg,
                                           input int                frac_bits);
      logic signed [31:0] zi;
      logic [7:0]         shade;
      zi = z >>> (frac_bits - 4);
      if (z < 0) begin
         shade = 8'hFF;
      end else if (zi > 32'sd255) begin
         shade = 8'h00;
      end else begin
         shade = 8'd255 - zi[7:0];
      end
      return hit ? {shade, shade, shade} : bg;
   endfunction

endpackage

// File: rtl/pixel_stream_packer_sync_fifo.sv
// rtl/pixel_stream_packer_sync_fifo.sv - parameterised first-word fall-through FIFO
// Purpose: single-clock FIFO whose head entry is visible on rd_data while
// empty is low; rd_en pops it. A write while full is accepted only when a
// read happens in the same cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  push request and data
//   rd_en, rd_data  pop request and head-of-queue data
//   count           current occupancy (0..DEPTH)
//   full, empty     occupancy flags
module pixel_stream_packer_sync_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   always_comb begin
      do_rd    = rd_en && (count_q != '0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      do_wr    = wr_en && ((count_q != (AW+1)'(DEPTH)) || do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);

endmodule

// File: rtl/pixel_stream_packer.sv
// rtl/pixel_stream_packer.sv - shades ray-march results into an AXI4-Stream video stream
// Purpose: registers a depth shade per incoming pixel, tags it with
// start-of-frame / end-of-line from raster counters, buffers it in a FWFT
// FIFO and presents the FIFO head as the AXIS beat.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   pixel_valid_in, hit_in,
//   surface_point_in                  raster-ordered pixel results (vec3 {x,y,z})
//   pixel_ready_out                   upstream throttle (registered)
//   m_axis_tdata/tvalid/tready/
//   m_axis_tuser/tlast                video stream, tuser = SOF, tlast = EOL
//   frame_done                        pulse with the handshake of a frame's last beat
//   overflow_err                      sticky, a pixel was dropped on a full FIFO
module pixel_stream_packer #(
   parameter int          IMG_WIDTH  = 8,
   parameter int          IMG_HEIGHT = 8,
   parameter int          FIFO_DEPTH = 16,
   parameter int          SKID       = 4,
   parameter int          FRAC_BITS  = pixel_stream_packer_pkg::FRAC_BITS,
   parameter logic [23:0] BG_COLOR   = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pixel_valid_in,
   input  logic        hit_in,
   input  logic [95:0] surface_point_in,
   output logic        pixel_ready_out,
   output logic [23:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tuser,
   output logic        m_axis_tlast,
   output logic        frame_done,
   output logic        overflow_err
);

   import pixel_stream_packer_pkg::*;

   localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int OW = AW + 2;
   localparam int PW = $bits(axis_pix_t);

   logic [XW-1:0] x_cnt_q, x_cnt_d;
   logic [YW-1:0] y_cnt_q, y_cnt_d;
   logic          s1_valid_q, s1_valid_d;
   axis_pix_t     s1_pix_q, s1_pix_d;
   logic          overflow_q, overflow_d;
   logic          ready_q, ready_d;
   logic [YW-1:0] out_line_q, out_line_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [AW:0]   fifo_count;
   logic [PW-1:0] fifo_rd_data;
   axis_pix_t     fifo_head;
   logic [OW-1:0] occ_next;
   logic [YW-1:0] line_base;
   logic          unused_xy;

   // Only depth drives the shade; x and y of the surface point are ignored.
   assign unused_xy = ^surface_point_in[95:32];
   assign fifo_head = axis_pix_t'(fifo_rd_data);

   always_comb begin
      s1_valid_d = pixel_valid_in;
      s1_pix_d   = s1_pix_q;
      x_cnt_d    = x_cnt_q;
      y_cnt_d    = y_cnt_q;
      out_line_d = out_line_q;
      frame_done = 1'b0;

      // Counters advance on every valid pixel, even ones later dropped, so
      // tags stay aligned with the upstream raster after an overflow.
      if (pixel_valid_in) begin
         s1_pix_d.rgb   = shade_depth(surface_point_in[31:0], hit_in, BG_COLOR, FRAC_BITS);
         s1_pix_d.tuser = (x_cnt_q == '0) && (y_cnt_q == '0);
         s1_pix_d.tlast = (x_cnt_q == XW'(IMG_WIDTH - 1));
         if (x_cnt_q == XW'(IMG_WIDTH - 1)) begin
            x_cnt_d = '0;
            y_cnt_d = (y_cnt_q == YW'(IMG_HEIGHT - 1)) ? '0 : y_cnt_q + 1'b1;
         end else begin
            x_cnt_d = x_cnt_q + 1'b1;
         end
      end

      fifo_pop   = !fifo_empty && m_axis_tready;
      fifo_push  = s1_valid_q && (!fifo_full || fifo_pop);
      overflow_d = overflow_q || (s1_valid_q && !fifo_push);

      // Throttle on next-cycle occupancy so the registered flag reflects the
      // state it is presented with; that keeps the full SKID window usable.
      occ_next = OW'(fifo_count) + OW'(fifo_push) - OW'(fifo_pop) + OW'(s1_valid_d);
      ready_d  = (occ_next < OW'(FIFO_DEPTH - SKID));

      // Output-side line count restarts on every tuser beat, independent of
      // the input raster counters.
      line_base = fifo_head.tuser ? '0 : out_line_q;
      if (fifo_pop) begin
         out_line_d = line_base;
         if (fifo_head.tlast) begin
            if (line_base == YW'(IMG_HEIGHT - 1)) begin
               frame_done = 1'b1;
               out_line_d = '0;
            end else begin
               out_line_d = line_base + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_pix_q   <= '0;
         overflow_q <= 1'b0;
         ready_q    <= 1'b1;
         out_line_q <= '0;
      end else begin
         x_cnt_q    <= x_cnt_d;
         y_cnt_q    <= y_cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_pix_q   <= s1_pix_d;
         overflow_q <= overflow_d;
         ready_q    <= ready_d;
         out_line_q <= out_line_d;
      end
   end

   pixel_stream_packer_sync_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_push),
      .wr_data (s1_pix_q),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The FIFO head is the beat; mask it while empty so idle outputs read 0.
   assign m_axis_tvalid   = !fifo_empty;
   assign m_axis_tdata    = fifo_empty ? '0   : fifo_head.rgb;
   assign m_axis_tuser    = fifo_empty ? 1'b0 : fifo_head.tuser;
   assign m_axis_tlast    = fifo_empty ? 1'b0 : fifo_head.tlast;
   assign pixel_ready_out = ready_q;
   assign overflow_err    = overflow_q;

endmodule
